// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipe_hazard_ctrl: stall/flush strobes for the 5-stage pipe registers.     |
// | Optional HAZARD_STATS_EN adds stall/flush counters. Rev 1.0               |
// +---------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int MEM_LAT      = 1,
    parameter int MUL_LAT      = 3,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mul_i,
    input  logic                  mem_br_taken_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  idex_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  exmem_flush_o,
`ifdef HAZARD_STATS_EN
    output logic [15:0]           stall_cycles_o,
    output logic [15:0]           flush_events_o,
`endif
    output logic                  busy_o
);

    localparam int MAX_A    = (MEM_LAT > MUL_LAT) ? MEM_LAT : MUL_LAT;
    localparam int MAX_P    = (MAX_A > FLUSH_CYCLES) ? MAX_A : FLUSH_CYCLES;
    localparam int CNT_W    = $clog2(MAX_P) + 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MULWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t             state_q, next_state;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f;
    logic               load_use;

    assign load_use = ex_memread_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= next_state;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        next_state = RUN;
        cnt_d      = '0;
        pc_w       = 1'b1;
        ifid_w     = 1'b1;
        idex_w     = 1'b1;
        ifid_f     = 1'b0;
        idex_f     = 1'b0;
        exmem_f    = 1'b0;
        if (mem_br_taken_i) begin
            ifid_f  = 1'b1;
            idex_f  = 1'b1;
            exmem_f = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state = FLUSH;
                cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
            end
        end else if (state_q != RUN && cnt_q != '0) begin
            // A stall state with a zero count falls through to the RUN decode.
            cnt_d      = cnt_q - 1'b1;
            next_state = (cnt_q == CNT_W'(1)) ? RUN : state_q;
            case (state_q)
                LDSTALL: begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    idex_f = 1'b1;
                end
                MULWAIT: begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_w  = 1'b0;
                    exmem_f = 1'b1;
                end
                FLUSH: begin
                    ifid_f  = 1'b1;
                    idex_f  = 1'b1;
                    exmem_f = 1'b1;
                end
                default: ;
            endcase
        end else if (ex_mul_i && (MUL_LAT > 1)) begin
            pc_w       = 1'b0;
            ifid_w     = 1'b0;
            idex_w     = 1'b0;
            exmem_f    = 1'b1;
            next_state = MULWAIT;
            cnt_d      = CNT_W'(MUL_LAT - 2);
        end else if (load_use) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_f = 1'b1;
            if (MEM_LAT > 1) begin
                next_state = LDSTALL;
                cnt_d      = CNT_W'(MEM_LAT - 1);
            end
        end
    end

    assign pc_write_o    = rst_i & pc_w;
    assign ifid_write_o  = rst_i & ifid_w;
    assign idex_write_o  = rst_i & idex_w;
    assign ifid_flush_o  = rst_i & ifid_f;
    assign idex_flush_o  = rst_i & idex_f;
    assign exmem_flush_o = rst_i & exmem_f;
    assign busy_o        = rst_i & (state_q != RUN);

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cycles_o <= '0;
            flush_events_o <= '0;
        end else begin
            if (!pc_write_o && stall_cycles_o != 16'hFFFF)
                stall_cycles_o <= stall_cycles_o + 16'd1;
            if (mem_br_taken_i && flush_events_o != 16'hFFFF)
                flush_events_o <= flush_events_o + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Directed bench: vector table on a default-parameter instance, hand sequences
// on a second instance with MEM_LAT=2 and FLUSH_CYCLES=2.
module tb_pipe_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs_i, id_rt_i, ex_rd_i;
    logic       id_uses_rt_i, ex_memread_i, ex_mul_i, mem_br_taken_i;

    logic pc0, ifw0, idw0, iff0, idf0, exf0, busy0;
    logic pc1, ifw1, idw1, iff1, idf1, exf1, busy1;
`ifdef HAZARD_STATS_EN
    logic [15:0] sc0, fe0, sc1, fe1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LAT(1), .MUL_LAT(3), .FLUSH_CYCLES(1)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .ex_mul_i(ex_mul_i), .mem_br_taken_i(mem_br_taken_i),
        .pc_write_o(pc0), .ifid_write_o(ifw0), .idex_write_o(idw0),
        .ifid_flush_o(iff0), .idex_flush_o(idf0), .exmem_flush_o(exf0),
`ifdef HAZARD_STATS_EN
        .stall_cycles_o(sc0), .flush_events_o(fe0),
`endif
        .busy_o(busy0));

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LAT(2), .MUL_LAT(3), .FLUSH_CYCLES(2)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_uses_rt_i(id_uses_rt_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .ex_mul_i(ex_mul_i), .mem_br_taken_i(mem_br_taken_i),
        .pc_write_o(pc1), .ifid_write_o(ifw1), .idex_write_o(idw1),
        .ifid_flush_o(iff1), .idex_flush_o(idf1), .exmem_flush_o(exf1),
`ifdef HAZARD_STATS_EN
        .stall_cycles_o(sc1), .flush_events_o(fe1),
`endif
        .busy_o(busy1));

    // Output bundle order: {pc, ifid_w, idex_w, ifid_f, idex_f, exmem_f, busy}
    localparam logic [6:0] IDLE  = 7'b111_000_0;
    localparam logic [6:0] LDU   = 7'b001_010_0;
    localparam logic [6:0] LDUB  = 7'b001_010_1;
    localparam logic [6:0] MUL0  = 7'b000_001_0;
    localparam logic [6:0] MULB  = 7'b000_001_1;
    localparam logic [6:0] BR    = 7'b111_111_0;
    localparam logic [6:0] BRB   = 7'b111_111_1;
    localparam logic [6:0] ZERO  = 7'b000_000_0;

    typedef struct {
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mul;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [6:0] out0();
        return {pc0, ifw0, idw0, iff0, idf0, exf0, busy0};
    endfunction

    function automatic logic [6:0] out1();
        return {pc1, ifw1, idw1, iff1, idf1, exf1, busy1};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic memread, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses_rt, input logic mul, input logic br);
        ex_memread_i   = memread;
        ex_rd_i        = rd;
        id_rs_i        = rs;
        id_rt_i        = rt;
        id_uses_rt_i   = uses_rt;
        ex_mul_i       = mul;
        mem_br_taken_i = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        idle();
        next_cycle();
        rst_i = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[1]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, LDU};
        vecs[2]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, IDLE};
        vecs[4]  = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[5]  = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, LDU};
        vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MUL0};
        vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MULB};
        vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MUL0};
        vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, BRB};
        vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[12] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, BR};
        vecs[13] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, MUL0};
        vecs[14] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, MULB};
        vecs[15] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, LDU};

        // Reset held with a branch pending: every output must stay low.
        rst_i = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check($sformatf("reset0_c%0d", i), {9'd0, out0()}, {9'd0, ZERO});
            check($sformatf("reset1_c%0d", i), {9'd0, out1()}, {9'd0, ZERO});
        end
        next_cycle();
        rst_i = 1'b1;
        idle();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].memread, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                  vecs[i].uses_rt, vecs[i].mul, vecs[i].br);
            @(negedge clk_i);
            check($sformatf("vec%0d", i), {9'd0, out0()}, {9'd0, vecs[i].exp});
            next_cycle();
        end
        idle();
        @(negedge clk_i);
        check("vec_tail_idle", {9'd0, out0()}, {9'd0, IDLE});
        next_cycle();

        // Two-cycle flush on the FLUSH_CYCLES=2 instance.
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i); check("fc2_br_c0", {9'd0, out1()}, {9'd0, BR});
        next_cycle(); idle();
        @(negedge clk_i); check("fc2_br_c1", {9'd0, out1()}, {9'd0, BRB});
        next_cycle();
        @(negedge clk_i); check("fc2_br_c2", {9'd0, out1()}, {9'd0, IDLE});
        next_cycle();

        // Two-bubble load-use on the MEM_LAT=2 instance.
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i); check("ml2_ld_c0", {9'd0, out1()}, {9'd0, LDU});
        next_cycle(); idle();
        @(negedge clk_i); check("ml2_ld_c1", {9'd0, out1()}, {9'd0, LDUB});
        next_cycle();
        @(negedge clk_i); check("ml2_ld_c2", {9'd0, out1()}, {9'd0, IDLE});
        next_cycle();

        // Reset asserted mid-multiply leaves no residual stall.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i); check("rstmid_mul", {9'd0, out1()}, {9'd0, MUL0});
        next_cycle(); idle();
        rst_i = 1'b0;
        #1;
        check("rstmid_low", {9'd0, out1()}, {9'd0, ZERO});
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk_i); check("rstmid_after", {9'd0, out1()}, {9'd0, IDLE});
        next_cycle();

`ifdef HAZARD_STATS_EN
        do_reset();
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0); next_cycle();
        idle(); next_cycle();
        drive(1'b1, 5'd6, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0); next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); next_cycle();
        idle(); next_cycle();
        check("stats_stall", sc0, 16'd2);
        check("stats_flush", fe0, 16'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
